// File: rtl/bna_axi_pkg.sv
// Shared AXI constants, the store-burst FSM state type and the AWSIZE helper
// used by the accumulator-row write sequencer.
package bna_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LOAD,
        ST_DATA,
        ST_RESP
    } wr_state_e;

    // AXI encodes the beat size as log2 of the byte count.
    function automatic logic [2:0] axi_size(input int bytes_per_beat);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes_per_beat) size = 3'(i);
        end
        return size;
    endfunction

endpackage

// File: rtl/store_wr_burst_ctrl.sv
// Drains one systolic-array accumulator row as a single AXI4 INCR write burst,
// steering the Store stage's word select and WDATA register load.
module store_wr_burst_ctrl
    import bna_axi_pkg::*;
#(
    parameter int AXI_WIDTH_ID     = 4,
    parameter int AXI_WIDTH_AD     = 32,
    parameter int AXI_WIDTH_DA     = 32,
    parameter int AXI_WIDTH_DS     = AXI_WIDTH_DA / 8,
    parameter int SYST_ARRAY_WIDTH = 32,
    parameter int SEL_WIDTH        = $clog2(SYST_ARRAY_WIDTH),
    parameter int AXI_ID_VALUE     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [AXI_WIDTH_AD-1:0] base_addr_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    store_data_reg_wr_en_o,
    output logic [SEL_WIDTH-1:0]    sel_store_data_o,
    output logic [AXI_WIDTH_ID-1:0] m_axi_memory_bus_AWID,
    output logic [AXI_WIDTH_AD-1:0] m_axi_memory_bus_AWADDR,
    output logic [7:0]              m_axi_memory_bus_AWLEN,
    output logic [2:0]              m_axi_memory_bus_AWSIZE,
    output logic [1:0]              m_axi_memory_bus_AWBURST,
    output logic                    m_axi_memory_bus_AWVALID,
    input  logic                    m_axi_memory_bus_AWREADY,
    output logic [AXI_WIDTH_DS-1:0] m_axi_memory_bus_WSTRB,
    output logic                    m_axi_memory_bus_WLAST,
    output logic                    m_axi_memory_bus_WVALID,
    input  logic                    m_axi_memory_bus_WREADY,
    input  logic [1:0]              m_axi_memory_bus_BRESP,
    input  logic                    m_axi_memory_bus_BVALID,
    output logic                    m_axi_memory_bus_BREADY
);

    // Aligning to a whole row keeps every burst inside one 4 KB page.
    localparam int                    ALIGN_BITS = $clog2(SYST_ARRAY_WIDTH * AXI_WIDTH_DS);
    localparam logic [AXI_WIDTH_AD-1:0] ADDR_MASK = {AXI_WIDTH_AD{1'b1}} << ALIGN_BITS;
    localparam logic [SEL_WIDTH-1:0]  LAST_BEAT  = SEL_WIDTH'(SYST_ARRAY_WIDTH - 1);

    wr_state_e               state;
    wr_state_e               state_nxt;
    logic [SEL_WIDTH-1:0]    beat;
    logic [AXI_WIDTH_AD-1:0] awaddr;
    logic                    err;
    logic                    last_beat;
    logic                    beat_adv;
    logic                    b_hs;
    logic                    start_acc;

    assign start_acc = (state == ST_IDLE) && start_i;
    assign last_beat = (beat == LAST_BEAT);
    assign beat_adv  = (state == ST_DATA) && m_axi_memory_bus_WREADY && !last_beat;
    assign b_hs      = (state == ST_RESP) && m_axi_memory_bus_BVALID;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the default assignment first guarantees no latch on any path.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start_i) state_nxt = ST_ADDR;
            ST_ADDR: if (m_axi_memory_bus_AWREADY) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_DATA;
            ST_DATA: if (m_axi_memory_bus_WREADY && last_beat) state_nxt = ST_RESP;
            ST_RESP: if (m_axi_memory_bus_BVALID) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat   <= '0;
            awaddr <= '0;
            err    <= 1'b0;
        end else if (start_acc) begin
            beat   <= '0;
            awaddr <= base_addr_i & ADDR_MASK;
            err    <= 1'b0;
        end else begin
            if (beat_adv) beat <= beat + SEL_WIDTH'(1);
            if (b_hs)     err  <= err | (m_axi_memory_bus_BRESP != AXI_RESP_OKAY);
        end
    end

    // While a beat is accepted, Store is told to fetch the next word so WDATA
    // is refreshed in the same edge and beats stream at one per cycle.
    assign store_data_reg_wr_en_o = (state == ST_LOAD) || beat_adv;
    assign sel_store_data_o       = beat_adv ? beat + SEL_WIDTH'(1) : beat;

    assign busy_o = (state != ST_IDLE);
    assign done_o = b_hs;
    assign err_o  = err;

    assign m_axi_memory_bus_AWID    = AXI_WIDTH_ID'(AXI_ID_VALUE);
    assign m_axi_memory_bus_AWADDR  = awaddr;
    assign m_axi_memory_bus_AWLEN   = 8'(SYST_ARRAY_WIDTH - 1);
    assign m_axi_memory_bus_AWSIZE  = axi_size(AXI_WIDTH_DS);
    assign m_axi_memory_bus_AWBURST = AXI_BURST_INCR;
    assign m_axi_memory_bus_AWVALID = (state == ST_ADDR);
    assign m_axi_memory_bus_WSTRB   = '1;
    assign m_axi_memory_bus_WLAST   = (state == ST_DATA) && last_beat;
    assign m_axi_memory_bus_WVALID  = (state == ST_DATA);
    assign m_axi_memory_bus_BREADY  = (state == ST_RESP);

endmodule

// File: tb/tb_store_wr_burst_ctrl.sv
// Directed bench for store_wr_burst_ctrl: a small Store register model and an
// AXI slave responder with configurable AW delay, W stall and BRESP.
module tb_store_wr_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic        busy, done, err, wr_en;
    logic [4:0]  sel;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, wlast, wvalid, bready;
    logic [3:0]  wstrb;
    logic        awready = 1'b0;
    logic        wready = 1'b1;
    logic        bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;

    store_wr_burst_ctrl dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .start_i                  (start),
        .base_addr_i              (base),
        .busy_o                   (busy),
        .done_o                   (done),
        .err_o                    (err),
        .store_data_reg_wr_en_o   (wr_en),
        .sel_store_data_o         (sel),
        .m_axi_memory_bus_AWID    (awid),
        .m_axi_memory_bus_AWADDR  (awaddr),
        .m_axi_memory_bus_AWLEN   (awlen),
        .m_axi_memory_bus_AWSIZE  (awsize),
        .m_axi_memory_bus_AWBURST (awburst),
        .m_axi_memory_bus_AWVALID (awvalid),
        .m_axi_memory_bus_AWREADY (awready),
        .m_axi_memory_bus_WSTRB   (wstrb),
        .m_axi_memory_bus_WLAST   (wlast),
        .m_axi_memory_bus_WVALID  (wvalid),
        .m_axi_memory_bus_WREADY  (wready),
        .m_axi_memory_bus_BRESP   (bresp),
        .m_axi_memory_bus_BVALID  (bvalid),
        .m_axi_memory_bus_BREADY  (bready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Accumulator row contents and the Store WDATA register they feed.
    logic [31:0] row [32];
    logic [31:0] wdata;
    initial for (int i = 0; i < 32; i++) row[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     wdata <= '0;
        else if (wr_en) wdata <= row[sel];
    end

    // Slave responder configuration.
    int         aw_delay   = 0;
    int         aw_cnt     = 0;
    int         stall_beat = -1;
    int         stall_left = 0;
    logic [1:0] cfg_bresp  = 2'b00;

    // Monitor state.
    int          w_cnt, aw_hs, aw_seen, early, data_bad, last_bad;
    int          stall_seen, stall_wren, stall_sel_bad, done_cnt;
    logic        err_at_addr;
    logic [31:0] cap_awaddr;
    logic [4:0]  sel_log [$];

    always @(posedge clk) begin
        #1;
        if (awvalid) begin
            awready = (aw_cnt >= aw_delay);
            aw_cnt++;
        end else begin
            awready = 1'b0;
            aw_cnt  = 0;
        end
        if (wvalid && w_cnt == stall_beat && stall_left > 0) begin
            wready = 1'b0;
            stall_left--;
        end else begin
            wready = 1'b1;
        end
        bvalid = bready;
        bresp  = bready ? cfg_bresp : 2'b00;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) sel_log.push_back(sel);
            if (awvalid && aw_seen == 0) err_at_addr = err;
            if ((wvalid || wr_en) && aw_seen == 0) early++;
            if (awvalid && awready) begin
                aw_hs++;
                aw_seen    = 1;
                cap_awaddr = awaddr;
            end
            if (wvalid && wready) begin
                if (w_cnt >= 32 || wdata !== row[w_cnt % 32]) data_bad++;
                if (wlast !== (w_cnt == 31)) last_bad++;
                w_cnt++;
            end
            if (wvalid && !wready) begin
                stall_seen++;
                if (wr_en) stall_wren++;
                if (32'(sel) != w_cnt) stall_sel_bad++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        w_cnt = 0; aw_hs = 0; aw_seen = 0; early = 0; data_bad = 0; last_bad = 0;
        stall_seen = 0; stall_wren = 0; stall_sel_bad = 0; done_cnt = 0;
        err_at_addr = 1'bx; cap_awaddr = 'x;
        sel_log.delete();
    endtask

    function automatic int sel_order_errors();
        int bad;
        bad = (sel_log.size() != 32) ? 1 : 0;
        for (int i = 0; i < sel_log.size(); i++) if (32'(sel_log[i]) != i) bad++;
        return bad;
    endfunction

    // Pulses start for one cycle (optionally a second time at cycle extra_at)
    // and returns the cycle count from the start cycle to the done cycle.
    task automatic run_burst(input logic [31:0] b, input int extra_at, output int lat);
        bit got;
        clear_mon();
        base  = b;
        start = 1'b1;
        lat   = 0;
        got   = 0;
        while (!got && lat < 2000) begin
            @(negedge clk);
            if (done) got = 1;
            else begin
                tick();
                lat++;
                start = (lat == extra_at);
            end
        end
        start = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL burst_timeout: done_o not seen within %0d cycles", lat);
            lat = -1;
        end
        tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++;
        if ({busy, done, err, awvalid, wvalid, wlast, bready, wr_en} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {busy, done, err, awvalid, wvalid, wlast, bready, wr_en});
        end
        n_checks++;
        if (sel !== 5'd0 || awaddr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_sel_addr: got sel=%0d addr=%h expected 0/0", sel, awaddr);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        run_burst(32'h1000_0040, -1, lat);
        n_checks++;
        if (cap_awaddr !== 32'h1000_0000) begin
            n_fail++;
            $display("FAIL basic_awaddr: got %h expected 10000000", cap_awaddr);
        end
        n_checks++;
        if ({awid, awlen, awsize, awburst, wstrb} !== {4'd0, 8'd31, 3'd2, 2'b01, 4'hf}) begin
            n_fail++;
            $display("FAIL basic_aw_fields: got id=%0d len=%0d size=%0d burst=%0d strb=%h expected 0/31/2/1/f",
                     awid, awlen, awsize, awburst, wstrb);
        end
        n_checks++;
        if (w_cnt !== 32) begin
            n_fail++;
            $display("FAIL basic_beats: got %0d expected 32", w_cnt);
        end
        n_checks++;
        if (sel_order_errors() !== 0) begin
            n_fail++;
            $display("FAIL basic_sel_order: got %0d bad entries (size %0d) expected 0", sel_order_errors(), sel_log.size());
        end
        n_checks++;
        if (data_bad !== 0 || last_bad !== 0) begin
            n_fail++;
            $display("FAIL basic_wdata_wlast: got data_bad=%0d last_bad=%0d expected 0/0", data_bad, last_bad);
        end
        n_checks++;
        if (lat !== 35) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 35", lat);
        end
        n_checks++;
        if (done_cnt !== 1 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: got done_cnt=%0d busy=%b err=%b expected 1/0/0", done_cnt, busy, err);
        end
    endtask

    task automatic test_wready_stall();
        int lat;
        stall_beat = 5;
        stall_left = 3;
        run_burst(32'h0000_2000, -1, lat);
        stall_beat = -1;
        n_checks++;
        if (stall_seen !== 3 || stall_wren !== 0 || stall_sel_bad !== 0) begin
            n_fail++;
            $display("FAIL stall_hold: got cycles=%0d wr_en=%0d sel_bad=%0d expected 3/0/0",
                     stall_seen, stall_wren, stall_sel_bad);
        end
        n_checks++;
        if (w_cnt !== 32 || data_bad !== 0 || sel_order_errors() !== 0) begin
            n_fail++;
            $display("FAIL stall_beats: got beats=%0d data_bad=%0d sel_bad=%0d expected 32/0/0",
                     w_cnt, data_bad, sel_order_errors());
        end
        n_checks++;
        if (lat !== 38) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d expected 38", lat);
        end
    endtask

    task automatic test_aw_delay();
        int lat;
        aw_delay = 10;
        run_burst(32'h0000_3000, -1, lat);
        aw_delay = 0;
        n_checks++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL awdelay_early_w: got %0d early W/wr_en cycles expected 0", early);
        end
        n_checks++;
        if (lat !== 45 || w_cnt !== 32) begin
            n_fail++;
            $display("FAIL awdelay_burst: got lat=%0d beats=%0d expected 45/32", lat, w_cnt);
        end
    endtask

    task automatic test_bresp_err();
        int lat;
        cfg_bresp = 2'b10;
        run_burst(32'h0000_4000, -1, lat);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got %b expected 1", err);
        end
        cfg_bresp = 2'b00;
        run_burst(32'h0000_4000, -1, lat);
        n_checks++;
        if (err_at_addr !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear_on_start: got %b expected 0", err_at_addr);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_okay_burst: got %b expected 0", err);
        end
    endtask

    task automatic test_start_in_data();
        int lat;
        int busy_after;
        run_burst(32'h0000_5000, 10, lat);
        busy_after = 0;
        repeat (5) begin
            tick();
            if (busy) busy_after++;
        end
        n_checks++;
        if (aw_hs !== 1 || done_cnt !== 1 || busy_after !== 0) begin
            n_fail++;
            $display("FAIL start_in_data: got aw=%0d done=%0d busy_cycles=%0d expected 1/1/0",
                     aw_hs, done_cnt, busy_after);
        end
        n_checks++;
        if (w_cnt !== 32 || lat !== 35) begin
            n_fail++;
            $display("FAIL start_in_data_burst: got beats=%0d lat=%0d expected 32/35", w_cnt, lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int guard;
        clear_mon();
        base  = 32'h2000_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (w_cnt < 12 && guard < 200) begin
            tick();
            guard++;
        end
        n_checks++;
        if (w_cnt !== 12) begin
            n_fail++;
            $display("FAIL rstmid_reach: got %0d beats expected 12", w_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, err, awvalid, wvalid, wlast, bready, wr_en} !== 8'h00
            || sel !== 5'd0 || awaddr !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got ctrl=%b sel=%0d addr=%h expected 0/0/0",
                     {busy, done, err, awvalid, wvalid, wlast, bready, wr_en}, sel, awaddr);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_burst(32'h2000_0000, -1, lat);
        n_checks++;
        if (sel_log.size() == 0 || sel_log[0] !== 5'd0) begin
            n_fail++;
            $display("FAIL rstmid_restart_sel: got first sel=%0d (log %0d) expected 0",
                     (sel_log.size() == 0) ? -1 : int'(sel_log[0]), sel_log.size());
        end
        n_checks++;
        if (w_cnt !== 32 || data_bad !== 0 || sel_order_errors() !== 0 || lat !== 35) begin
            n_fail++;
            $display("FAIL rstmid_restart_burst: got beats=%0d data_bad=%0d sel_bad=%0d lat=%0d expected 32/0/0/35",
                     w_cnt, data_bad, sel_order_errors(), lat);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_wready_stall();
        test_aw_delay();
        test_bresp_err();
        test_start_in_data();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
